// File: rtl/hazard_forward_unit_if.sv
// ID-stage instruction fields, pipeline controls, and registered forwarding results
// exchanged between the pipeline (master) and the hazard/forwarding unit (slave).
interface hazard_forward_unit_if #(
  parameter int AW        = 5,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int CNT_W     = 16
);
  localparam int SEL_W = $clog2(FWD_DEPTH + 1);

  logic                     freeze;
  logic                     flush;
  logic                     id_valid;
  logic [AW-1:0]            id_rd;
  logic                     id_regwrite;
  logic                     id_load;
  logic [NUM_SRC*AW-1:0]    id_src_addr;
  logic [NUM_SRC-1:0]       id_src_used;
  logic [NUM_SRC-1:0]       id_src_late;
  logic                     hazard_stall;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic [NUM_SRC-1:0]       fwd_late;
  logic [CNT_W-1:0]         stall_count;

  modport master (
    output freeze, flush, id_valid, id_rd, id_regwrite, id_load,
           id_src_addr, id_src_used, id_src_late,
    input  hazard_stall, fwd_sel, fwd_late, stall_count
  );

  modport slave (
    input  freeze, flush, id_valid, id_rd, id_regwrite, id_load,
           id_src_addr, id_src_used, id_src_late,
    output hazard_stall, fwd_sel, fwd_late, stall_count
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Operand forwarding + load-use hazard detection for the ID instruction; selects registered (1 cycle, align with ID/EX),
// stall combinational; freeze holds all state, flush/stall push a bubble into the private destination-tag pipeline.
module hazard_forward_unit #(
  parameter int AW         = 5,
  parameter int NUM_SRC    = 2,
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_forward_unit_if.slave hfu_bus
);
  localparam int SEL_W = $clog2(FWD_DEPTH + 1);

  generate
    if (FWD_DEPTH < 1 || LOAD_STAGE < 1 || LOAD_STAGE > FWD_DEPTH) begin : g_bad_params
      $error("hazard_forward_unit: need FWD_DEPTH>=1 and 1<=LOAD_STAGE<=FWD_DEPTH");
    end
  endgenerate

  logic [FWD_DEPTH-1:0]     r_t_vld;
  logic [FWD_DEPTH-1:0]     r_t_wr;
  logic [FWD_DEPTH-1:0]     r_t_ld;
  logic [AW-1:0]            r_t_rd [FWD_DEPTH];
  logic [NUM_SRC*SEL_W-1:0] r_fwd_sel;
  logic [NUM_SRC-1:0]       r_fwd_late;
  logic [CNT_W-1:0]         r_stall_count;

  logic [NUM_SRC*SEL_W-1:0] w_fwd_sel;
  logic [NUM_SRC-1:0]       w_fwd_late;
  logic [NUM_SRC-1:0]       w_src_stall;
  logic                     w_stall;

  // Scan oldest to youngest so the youngest matching tag is the one left standing.
  always_comb begin
    logic          hit;
    logic          hit_ld;
    int            stage;
    logic [AW-1:0] src;
    w_fwd_sel   = '0;
    w_fwd_late  = '0;
    w_src_stall = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      src    = hfu_bus.id_src_addr[j*AW +: AW];
      hit    = 1'b0;
      hit_ld = 1'b0;
      stage  = 0;
      for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
        if (r_t_vld[i] && r_t_wr[i] && (r_t_rd[i] != '0) && (r_t_rd[i] == src) &&
            hfu_bus.id_src_used[j]) begin
          hit    = 1'b1;
          hit_ld = r_t_ld[i];
          stage  = i + 1;
        end
      end
      if (hit) begin
        w_fwd_sel[j*SEL_W +: SEL_W] = SEL_W'(stage);
        if (hit_ld && (stage < LOAD_STAGE - int'(hfu_bus.id_src_late[j])))
          w_src_stall[j] = 1'b1;
        if (hfu_bus.id_src_late[j] && hit_ld && (stage == LOAD_STAGE - 1))
          w_fwd_late[j] = 1'b1;
      end
    end
    w_stall = hfu_bus.id_valid && !hfu_bus.flush && (|w_src_stall);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t_vld       <= '0;
      r_t_wr        <= '0;
      r_t_ld        <= '0;
      for (int i = 0; i < FWD_DEPTH; i++) r_t_rd[i] <= '0;
      r_fwd_sel     <= '0;
      r_fwd_late    <= '0;
      r_stall_count <= '0;
    end else if (!hfu_bus.freeze) begin
      for (int i = 1; i < FWD_DEPTH; i++) begin
        r_t_vld[i] <= r_t_vld[i-1];
        r_t_wr[i]  <= r_t_wr[i-1];
        r_t_ld[i]  <= r_t_ld[i-1];
        r_t_rd[i]  <= r_t_rd[i-1];
      end
      if (hfu_bus.flush || w_stall) begin
        r_t_vld[0] <= 1'b0;
        r_t_wr[0]  <= 1'b0;
        r_t_ld[0]  <= 1'b0;
        r_t_rd[0]  <= '0;
        r_fwd_sel  <= '0;
        r_fwd_late <= '0;
        if (w_stall && (r_stall_count != {CNT_W{1'b1}}))
          r_stall_count <= r_stall_count + 1'b1;
      end else begin
        r_t_vld[0] <= hfu_bus.id_valid;
        r_t_wr[0]  <= hfu_bus.id_regwrite;
        r_t_ld[0]  <= hfu_bus.id_load;
        r_t_rd[0]  <= hfu_bus.id_rd;
        r_fwd_sel  <= hfu_bus.id_valid ? w_fwd_sel : '0;
        r_fwd_late <= hfu_bus.id_valid ? w_fwd_late : '0;
      end
    end
  end

  assign hfu_bus.hazard_stall = w_stall;
  assign hfu_bus.fwd_sel      = r_fwd_sel;
  assign hfu_bus.fwd_late     = r_fwd_late;
  assign hfu_bus.stall_count  = r_stall_count;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench: default-parameter unit plus a deep-load, 2-bit-counter unit fed the same ID stream.
module tb_hazard_forward_unit;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  hazard_forward_unit_if #(.AW(5), .NUM_SRC(2), .FWD_DEPTH(2), .CNT_W(16)) bus ();
  hazard_forward_unit_if #(.AW(5), .NUM_SRC(2), .FWD_DEPTH(4), .CNT_W(2))  bus2 ();

  hazard_forward_unit #(.AW(5), .NUM_SRC(2), .FWD_DEPTH(2), .LOAD_STAGE(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .hfu_bus(bus)
  );
  hazard_forward_unit #(.AW(5), .NUM_SRC(2), .FWD_DEPTH(4), .LOAD_STAGE(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .hfu_bus(bus2)
  );

  assign bus2.freeze      = bus.freeze;
  assign bus2.flush       = bus.flush;
  assign bus2.id_valid    = bus.id_valid;
  assign bus2.id_rd       = bus.id_rd;
  assign bus2.id_regwrite = bus.id_regwrite;
  assign bus2.id_load     = bus.id_load;
  assign bus2.id_src_addr = bus.id_src_addr;
  assign bus2.id_src_used = bus.id_src_used;
  assign bus2.id_src_late = bus.id_src_late;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rd, input logic wr, input logic ld,
                        input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] used, input logic [1:0] late);
    bus.id_valid    = v;
    bus.id_rd       = rd;
    bus.id_regwrite = wr;
    bus.id_load     = ld;
    bus.id_src_addr = {s1, s0};
    bus.id_src_used = used;
    bus.id_src_late = late;
    #1;
  endtask

  task automatic nop_id();
    set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 2'b00);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    nop_id();
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.freeze = 1'b0;
    bus.flush  = 1'b0;
    nop_id();
    #12;
    chk("reset_stall", bus.hazard_stall, 0);
    chk("reset_sel",   bus.fwd_sel,      0);
    chk("reset_late",  bus.fwd_late,     0);
    chk("reset_count", bus.stall_count,  0);
    rst_n = 1'b1;
    step();

    // add r2 ; and r12,r2,r5
    set_id(1, 5'd2, 1, 0, 5'd3, 5'd4, 2'b11, 2'b00); step();
    set_id(1, 5'd12, 1, 0, 5'd2, 5'd5, 2'b11, 2'b00);
    chk("b2b_nostall", bus.hazard_stall, 0);
    step();
    chk("b2b_sel", bus.fwd_sel, 4'b0001);
    chk("b2b_late", bus.fwd_late, 0);
    drain(2);

    // add r2 ; nop ; or r13,r6,r2
    set_id(1, 5'd2, 1, 0, 5'd3, 5'd4, 2'b11, 2'b00); step();
    nop_id(); step();
    set_id(1, 5'd13, 1, 0, 5'd6, 5'd2, 2'b11, 2'b00); step();
    chk("gap_sel", bus.fwd_sel, 4'b1000);
    drain(2);

    // add r2 ; sub r2 ; or r13,r6,r2 -> youngest
    set_id(1, 5'd2, 1, 0, 5'd3, 5'd4, 2'b11, 2'b00); step();
    set_id(1, 5'd2, 1, 0, 5'd7, 5'd8, 2'b11, 2'b00); step();
    set_id(1, 5'd13, 1, 0, 5'd6, 5'd2, 2'b11, 2'b00); step();
    chk("youngest_sel", bus.fwd_sel, 4'b0100);
    drain(2);

    // sub r2 ; sub r3 ; sub r4,r3,r2
    set_id(1, 5'd2, 1, 0, 5'd7, 5'd8, 2'b11, 2'b00); step();
    set_id(1, 5'd3, 1, 0, 5'd7, 5'd8, 2'b11, 2'b00); step();
    set_id(1, 5'd4, 1, 0, 5'd3, 5'd2, 2'b11, 2'b00); step();
    chk("dual_sel", bus.fwd_sel, 4'b1001);
    drain(2);

    // lw r4 ; add r5,r4,r1
    set_id(1, 5'd4, 1, 1, 5'd9, 5'd0, 2'b01, 2'b00); step();
    set_id(1, 5'd5, 1, 0, 5'd4, 5'd1, 2'b11, 2'b00);
    chk("lu_stall", bus.hazard_stall, 1);
    step();
    chk("lu_bubble_sel", bus.fwd_sel, 0);
    chk("lu_count", bus.stall_count, 1);
    chk("lu_stall_end", bus.hazard_stall, 0);
    step();
    chk("lu_sel", bus.fwd_sel, 4'b0010);
    drain(2);

    // lw r0 ; add r5,r0,r0
    set_id(1, 5'd0, 1, 1, 5'd9, 5'd0, 2'b01, 2'b00); step();
    set_id(1, 5'd5, 1, 0, 5'd0, 5'd0, 2'b11, 2'b00);
    chk("r0_nostall", bus.hazard_stall, 0);
    step();
    chk("r0_sel", bus.fwd_sel, 0);
    drain(2);

    // lw r4 ; sw r4,(r6) late store data
    set_id(1, 5'd4, 1, 1, 5'd9, 5'd0, 2'b01, 2'b00); step();
    set_id(1, 5'd0, 0, 0, 5'd6, 5'd4, 2'b11, 2'b10);
    chk("sw_late_nostall", bus.hazard_stall, 0);
    step();
    chk("sw_late_sel", bus.fwd_sel, 4'b0100);
    chk("sw_late_flag", bus.fwd_late, 2'b10);
    drain(2);

    // same store without late consumption stalls one cycle
    set_id(1, 5'd4, 1, 1, 5'd9, 5'd0, 2'b01, 2'b00); step();
    set_id(1, 5'd0, 0, 0, 5'd6, 5'd4, 2'b11, 2'b00);
    chk("sw_stall", bus.hazard_stall, 1);
    step();
    chk("sw_stall_end", bus.hazard_stall, 0);
    chk("sw_count", bus.stall_count, 2);
    step();
    chk("sw_sel", bus.fwd_sel, 4'b1000);
    chk("sw_late_zero", bus.fwd_late, 0);
    drain(2);

    // freeze during a stall: add r9 ; lw r4,(r9) ; add r5,r4,r1
    set_id(1, 5'd9, 1, 0, 5'd1, 5'd2, 2'b11, 2'b00); step();
    set_id(1, 5'd4, 1, 1, 5'd9, 5'd0, 2'b01, 2'b00); step();
    chk("frz_pre_sel", bus.fwd_sel, 4'b0001);
    set_id(1, 5'd5, 1, 0, 5'd4, 5'd1, 2'b11, 2'b00);
    chk("frz_pre_stall", bus.hazard_stall, 1);
    bus.freeze = 1'b1;
    step();
    chk("frz_sel_hold", bus.fwd_sel, 4'b0001);
    chk("frz_count_hold", bus.stall_count, 2);
    chk("frz_stall_still", bus.hazard_stall, 1);
    bus.freeze = 1'b0;
    step();
    chk("frz_post_count", bus.stall_count, 3);
    chk("frz_post_bubble", bus.fwd_sel, 0);
    chk("frz_post_nostall", bus.hazard_stall, 0);
    step();
    chk("frz_post_sel", bus.fwd_sel, 4'b0010);
    drain(2);

    // flush with a hazard pending
    set_id(1, 5'd4, 1, 1, 5'd9, 5'd0, 2'b01, 2'b00); step();
    set_id(1, 5'd5, 1, 0, 5'd4, 5'd1, 2'b11, 2'b00);
    bus.flush = 1'b1;
    #1;
    chk("flush_nostall", bus.hazard_stall, 0);
    step();
    bus.flush = 1'b0;
    nop_id();
    chk("flush_count", bus.stall_count, 3);
    chk("flush_sel", bus.fwd_sel, 0);
    drain(2);

    // asynchronous reset in the middle of a stall
    set_id(1, 5'd9, 1, 0, 5'd1, 5'd2, 2'b11, 2'b00); step();
    set_id(1, 5'd4, 1, 1, 5'd9, 5'd0, 2'b01, 2'b00); step();
    set_id(1, 5'd5, 1, 0, 5'd4, 5'd1, 2'b11, 2'b00);
    chk("rst_pre_stall", bus.hazard_stall, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_stall", bus.hazard_stall, 0);
    chk("rst_mid_sel",   bus.fwd_sel,      0);
    chk("rst_mid_late",  bus.fwd_late,     0);
    chk("rst_mid_count", bus.stall_count,  0);
    nop_id();
    #2;
    rst_n = 1'b1;
    step();

    // deep load stage unit: three-cycle stall, then saturating 2-bit counter
    set_id(1, 5'd4, 1, 1, 5'd9, 5'd0, 2'b01, 2'b00); step();
    set_id(1, 5'd5, 1, 0, 5'd4, 5'd1, 2'b11, 2'b00);
    for (int k = 0; k < 3; k++) begin
      chk("deep_stall", bus2.hazard_stall, 1);
      step();
    end
    chk("deep_stall_end", bus2.hazard_stall, 0);
    chk("deep_count", bus2.stall_count, 3);
    step();
    chk("deep_sel", bus2.fwd_sel, 6'b000100);
    drain(4);
    set_id(1, 5'd4, 1, 1, 5'd9, 5'd0, 2'b01, 2'b00); step();
    set_id(1, 5'd5, 1, 0, 5'd4, 5'd1, 2'b11, 2'b00);
    for (int k = 0; k < 3; k++) step();
    chk("deep_count_sat", bus2.stall_count, 3);
    drain(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised successor to the pipeline's forwarding logic. It combines operand forwarding and load-use hazard detection in one block and owns its own destination-tag pipeline.
- Supports any number of read ports and forwarding stages, a configurable load-data availability stage, and late-consumed operands (store data).
- Evaluates the instruction in ID. Registers the per-source forwarding selects so they align with the ID/EX register. Raises a combinational stall and inserts a bubble on load-use hazards.

Parameters:
AW, 5, register address width; address 0 never forwards or stalls
NUM_SRC, 2, number of source operands per instruction
FWD_DEPTH, 2, tag stages tracked after ID (1=EX/MEM ... FWD_DEPTH=last forwardable stage, MEM/WB)
LOAD_STAGE, 2, first tag stage at which a load result is forwardable (1..FWD_DEPTH)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
freeze  in  1  global pipeline hold (e.g. memory wait)
flush  in  1  kill the instruction in ID
id_valid  in  1  ID holds a real instruction
id_rd  in  AW  ID destination register
id_regwrite  in  1  ID instruction writes id_rd
id_load  in  1  ID instruction is a load
id_src_addr  in  NUM_SRC*AW  source addresses, source j at [j*AW +: AW]
id_src_used  in  NUM_SRC  source j is actually read
id_src_late  in  NUM_SRC  source j is consumed one stage later (store data)
hazard_stall  out  1  combinational: hold PC and IF/ID, bubble into EX
fwd_sel  out  NUM_SRC*SEL_W  registered; SEL_W=$clog2(FWD_DEPTH+1); 0=register file, k=stage k
fwd_late  out  NUM_SRC  registered; operand taken from stage fwd_sel+1 one cycle later
stall_count  out  CNT_W  saturating count of hazard_stall cycles

Behaviour:
- Tags T[0..FWD_DEPTH-1] are internal. T[0] = instruction now in EX.
- Each tag holds {valid, rd, wr, ld}. A tag matches source j when valid && wr && rd!=0 && rd==src_j && id_src_used[j].
- Match position: T[i] matching now means the producer sits in stage i+1 when the consumer reaches EX. The youngest match (smallest i) wins. No match gives sel 0.
- Stall rule: the youngest match is ld and stage i+1 < LOAD_STAGE - id_src_late[j].
  - hazard_stall = id_valid && !flush && any source stalls.
  - Older matches are ignored for the stall decision.
- fwd_late[j] = id_src_late[j] && youngest match is ld && stage i+1 == LOAD_STAGE-1; in that case sel = LOAD_STAGE-1. Otherwise fwd_late[j] = 0.
- Clock-edge priority: reset > freeze > flush > hazard_stall > normal.
  - freeze: all tags, fwd_sel, fwd_late and stall_count hold. hazard_stall is still driven combinationally.
  - flush: T shifts, T[0] <= bubble (valid=0), fwd_sel/fwd_late <= 0.
  - hazard_stall: T shifts, T[0] <= bubble, fwd_sel/fwd_late <= 0, stall_count += 1 (saturate at all ones).
  - normal: T shifts, T[0] <= {id_valid, id_rd, id_regwrite, id_load}, fwd_sel/fwd_late <= computed values. Invalid ID gives a bubble and zero selects.
- The shift is T[i+1] <= T[i]. The oldest tag drops off; its write reaches the register file, which must be write-before-read.
- Reset (asynchronous, any time including mid-stall): all tags invalid, fwd_sel=0, fwd_late=0, stall_count=0. hazard_stall is therefore 0 while rst_n is low.
- A stall lasts exactly until the load advances to a forwardable stage: (LOAD_STAGE-1-i) cycles for a normal source, no freeze.
- Multiple sources resolve independently: each source may select a different stage in the same cycle.
- Parameter legality, checked at elaboration: FWD_DEPTH>=1, 1<=LOAD_STAGE<=FWD_DEPTH.

Test Plan:
- Defaults. Issue add r2 then and r12,r2,r5 back-to-back -> after the second enters EX, fwd_sel[0]=1, fwd_sel[1]=0, hazard_stall never asserted.
- add r2; nop; or r13,r6,r2 -> fwd_sel[1]=2. Repeat with add r2 and sub r2 back-to-back -> youngest wins, fwd_sel=1.
- Dual source. sub r2; sub r3; sub r4,r3,r2 -> fwd_sel[0]=1, fwd_sel[1]=2 in the same cycle.
- Load-use. lw r4; add r5,r4,r1 -> hazard_stall=1 for exactly 1 cycle, bubble inserted, then fwd_sel[0]=2, stall_count=1. Source r0 with a load to r0 -> no stall.
- Store data. lw r4; sw r4 with id_src_late[1]=1 -> no stall, fwd_sel[1]=1, fwd_late[1]=1. The same sw with id_src_late=0 -> stall one cycle.
- Control. freeze during a stall -> tags, stall_count and fwd_sel hold. flush with a hazard pending -> hazard_stall=0, count unchanged. rst_n low mid-stall -> all outputs 0 immediately. Force stall_count to all ones -> stays saturated.
